studio2_keypad_ctrl: RTL and testbench
======================================

Name: studio2_keypad_ctrl

Overview:
- Parametrised keypad controller for the Studio II console core; replaces the inline single-pad PS/2 latch in the top level.
- Tracks make and break events from the PS/2 key bus per pad, with a minimum-press stretch.
- Decodes the keypad-select OUT port from the CDP1802 and drives the active-low EF3/EF4 flags: a flag goes low when the selected digit is held on that pad.
- Sits between hps_io's ps2_key and the cdp1802 EF/io ports.

Parameters:
- NUM_PADS, 2, number of keypads (1 or 2); pad 0 drives ef_n[0] (EF3), pad 1 drives ef_n[1] (EF4).
- KEYS_PER_PAD, 10, digits per pad (1..16); selects at or above this value never match.
- HOLD_CYCLES, 1000000, minimum clk cycles a key reads as pressed after its make event; 0 disables stretching.
- SEL_PORT, 2, CPU io_n value whose OUT writes the key select.

Ports:
- clk in 1: system clock.
- reset in 1: synchronous, active-high.
- ps2_key in 11: [10] event toggle, [9] 1=make/0=break, [8] extended, [7:0] scancode.
- io_out in 1: CPU OUT strobe, one cycle.
- io_n in 3: CPU N lines.
- io_dout in 8: CPU OUT data.
- ef_n out NUM_PADS: active-low key-match flags.
- key_sel out 4: current select value.
- key_down out NUM_PADS*KEYS_PER_PAD: effective pressed mask; bit p*KEYS_PER_PAD+k = pad p, digit k.
- key_code out 8: see Optional Feature.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: ef_n all 1, key_sel 0, key_down 0, key_code 8'hFF, hold counters 0. old_toggle loads ps2_key[10], so reset never produces a spurious event.
- Event detect: event when ps2_key[10] != old_toggle; old_toggle updates every cycle.
- Scancodes with ps2_key[8]=1 are ignored.
- Pad 0 map (main row): 45,16,1E,26,25,2E,36,3D,3E,46 → digits 0..9.
- Pad 1 map (numpad): 70,69,72,7A,6B,73,74,6C,75,7D → digits 0..9.
- Unmapped codes are ignored, as are digits >= KEYS_PER_PAD and pads >= NUM_PADS.
- Per key, raw bit down[p][k]: set on make, cleared on break.
- Per key, stretch bit st[p][k]: set on make when HOLD_CYCLES>0.
- Per pad, hold counter cnt[p] (width clog2(HOLD_CYCLES+1)):
  - any make on pad p reloads it to HOLD_CYCLES;
  - otherwise it decrements while nonzero;
  - on the cycle it reaches 0, all st[p][*] clear.
  - A make on the same cycle as expiry wins: counter reloads and that key's st sets.
- Effective state: key_down[p][k] = down | st. It is registered and updates 1 cycle after the event.
- A break during the hold window keeps the key active until the counter expires.
- Select: io_out && io_n==SEL_PORT loads key_sel <= io_dout[3:0]. Other ports and io_dout[7:4] are ignored.
- Flag: ef_n[p] <= ~(key_sel < KEYS_PER_PAD && key_down[p][key_sel]), registered.
  - Latency is 2 cycles from a PS/2 event and 1 cycle from a select write.
- Simultaneous select write and key event on the same cycle: both apply; ef_n reflects both 2 cycles later.
- Repeated make (typematic) of a held key: down stays 1, counter reloads.
- Reset mid-hold: all state clears immediately.

Optional Feature:
- Macro STUDIO2_KEYPAD_CODE_EN.
- Defined: key_code is registered (1 cycle after key_down) as {pad[3:0], digit[3:0]} of the lowest-index active bit in key_down; 8'hFF when none. This supports direct INP reads and debug.
- Undefined: key_code is tied to 8'hFF and the priority encoder is not built.

Test Plan:
1. Reset (HOLD_CYCLES=8), toggle ps2_key with make 0x1E (pad0 digit 2) -> key_down bit 2 =1 at event+1; ef_n stays 2'b11 while key_sel=0.
2. OUT io_n=2 io_dout=8'h02, then make 0x1E -> ef_n=2'b10 two cycles after the event; break at event+3 -> ef_n stays 2'b10 until counter expiry (event+9), then 2'b11 one cycle later.
3. Make 0x7A (numpad 3) with key_sel=3, held 50 cycles -> ef_n=2'b01 throughout; break -> ef_n=2'b11 within 2 cycles once hold has expired; pad0 unaffected.
4. OUT io_n=2 io_dout=8'h0C with all ten pad0 keys held -> ef_n=2'b11 (select >= KEYS_PER_PAD); OUT on io_n=3 -> key_sel unchanged.
5. Hold key, assert reset for 1 cycle with ps2_key[10]=1 -> all outputs return to reset values; no event detected after reset release.
6. With STUDIO2_KEYPAD_CODE_EN, make 0x2E then 0x69 -> key_code=8'h05, then 8'h05 (lowest index wins); break both after expiry -> 8'hFF.

Source files
------------

// File: rtl/studio2_keypad_ctrl.sv
// Studio II keypad controller: PS/2 make/break tracking per pad with a press stretch,
// CDP1802 select-port decode and active-low EF flags. Optional macro: STUDIO2_KEYPAD_CODE_EN.

module studio2_keypad_pad #(
  parameter int KEYS_PER_PAD = 10,
  parameter int HOLD_CYCLES  = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [KEYS_PER_PAD-1:0] mk,
  input  logic [KEYS_PER_PAD-1:0] brk,
  output logic [KEYS_PER_PAD-1:0] key_down
);
  localparam int CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  logic [KEYS_PER_PAD-1:0] down, st, down_nxt, st_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic                    expire;

  // Expiry clears the whole pad's stretch; a make on the same edge re-arms its own key.
  always_comb begin
    expire   = (cnt == CW'(1));
    down_nxt = (down | mk) & ~brk;
    st_nxt   = (expire ? '0 : st) | ((HOLD_CYCLES > 0) ? mk : '0);
    cnt_nxt  = cnt;
    if ((HOLD_CYCLES > 0) && (|mk)) cnt_nxt = CW'(HOLD_CYCLES);
    else if (cnt != '0)             cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      down     <= '0;
      st       <= '0;
      cnt      <= '0;
      key_down <= '0;
    end else begin
      down     <= down_nxt;
      st       <= st_nxt;
      cnt      <= cnt_nxt;
      key_down <= down_nxt | st_nxt;
    end
  end
endmodule

module studio2_keypad_ctrl #(
  parameter int NUM_PADS     = 2,
  parameter int KEYS_PER_PAD = 10,
  parameter int HOLD_CYCLES  = 1000000,
  parameter int SEL_PORT     = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [10:0]                      ps2_key,
  input  logic                             io_out,
  input  logic [2:0]                       io_n,
  input  logic [7:0]                       io_dout,
  output logic [NUM_PADS-1:0]              ef_n,
  output logic [3:0]                       key_sel,
  output logic [NUM_PADS*KEYS_PER_PAD-1:0] key_down,
  output logic [7:0]                       key_code
);
  localparam int NK = NUM_PADS * KEYS_PER_PAD;

  typedef struct packed {
    logic       hit;
    logic       pad;
    logic [3:0] digit;
  } key_map_t;

  function automatic key_map_t decode(input logic [7:0] sc);
    key_map_t m;
    m = '0;
    case (sc)
      8'h45: m = '{1'b1, 1'b0, 4'd0};
      8'h16: m = '{1'b1, 1'b0, 4'd1};
      8'h1E: m = '{1'b1, 1'b0, 4'd2};
      8'h26: m = '{1'b1, 1'b0, 4'd3};
      8'h25: m = '{1'b1, 1'b0, 4'd4};
      8'h2E: m = '{1'b1, 1'b0, 4'd5};
      8'h36: m = '{1'b1, 1'b0, 4'd6};
      8'h3D: m = '{1'b1, 1'b0, 4'd7};
      8'h3E: m = '{1'b1, 1'b0, 4'd8};
      8'h46: m = '{1'b1, 1'b0, 4'd9};
      8'h70: m = '{1'b1, 1'b1, 4'd0};
      8'h69: m = '{1'b1, 1'b1, 4'd1};
      8'h72: m = '{1'b1, 1'b1, 4'd2};
      8'h7A: m = '{1'b1, 1'b1, 4'd3};
      8'h6B: m = '{1'b1, 1'b1, 4'd4};
      8'h73: m = '{1'b1, 1'b1, 4'd5};
      8'h74: m = '{1'b1, 1'b1, 4'd6};
      8'h6C: m = '{1'b1, 1'b1, 4'd7};
      8'h75: m = '{1'b1, 1'b1, 4'd8};
      8'h7D: m = '{1'b1, 1'b1, 4'd9};
      default: m = '0;
    endcase
    return m;
  endfunction

  logic       old_toggle, ev;
  key_map_t   km;
  logic [3:0] sel_nxt;
  logic [NK-1:0] mk, brk;
  logic [NUM_PADS-1:0] match;
  logic unused_dout;

  assign unused_dout = ^io_dout[7:4];
  assign ev          = (ps2_key[10] != old_toggle) && !ps2_key[8];
  assign km          = decode(ps2_key[7:0]);
  assign sel_nxt     = (io_out && io_n == 3'(SEL_PORT)) ? io_dout[3:0] : key_sel;

  genvar p;
  generate
    for (p = 0; p < NUM_PADS; p++) begin : g_pad
      logic valid;
      logic [KEYS_PER_PAD-1:0] onehot;
      assign valid  = ev && km.hit && (km.pad == 1'(p)) && (int'(km.digit) < KEYS_PER_PAD);
      assign onehot = valid ? (KEYS_PER_PAD'(1) << km.digit) : '0;
      assign mk [p*KEYS_PER_PAD +: KEYS_PER_PAD] = ps2_key[9]  ? onehot : '0;
      assign brk[p*KEYS_PER_PAD +: KEYS_PER_PAD] = !ps2_key[9] ? onehot : '0;

      studio2_keypad_pad #(.KEYS_PER_PAD(KEYS_PER_PAD), .HOLD_CYCLES(HOLD_CYCLES)) u_pad (
        .clk     (clk),
        .reset   (reset),
        .mk      (mk [p*KEYS_PER_PAD +: KEYS_PER_PAD]),
        .brk     (brk[p*KEYS_PER_PAD +: KEYS_PER_PAD]),
        .key_down(key_down[p*KEYS_PER_PAD +: KEYS_PER_PAD])
      );

      // Selects at or above KEYS_PER_PAD have no matching key and never drive the flag low.
      always_comb begin
        match[p] = 1'b0;
        for (int k = 0; k < KEYS_PER_PAD; k++)
          if (sel_nxt == 4'(k) && key_down[p*KEYS_PER_PAD + k]) match[p] = 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      old_toggle <= ps2_key[10];
      key_sel    <= '0;
      ef_n       <= '1;
    end else begin
      old_toggle <= ps2_key[10];
      key_sel    <= sel_nxt;
      ef_n       <= ~match;
    end
  end

`ifdef STUDIO2_KEYPAD_CODE_EN
  logic [7:0] code_nxt;

  always_comb begin
    code_nxt = 8'hFF;
    for (int i = NK - 1; i >= 0; i--)
      if (key_down[i]) code_nxt = {4'(i / KEYS_PER_PAD), 4'(i % KEYS_PER_PAD)};
  end

  always_ff @(posedge clk) begin
    if (reset) key_code <= 8'hFF;
    else       key_code <= code_nxt;
  end
`else
  assign key_code = 8'hFF;
`endif
endmodule

// File: tb/tb_studio2_keypad_ctrl.sv
// Bench for studio2_keypad_ctrl: directed plan scenarios with literal pins, then random
// PS/2 and select traffic checked each cycle against a deadline-based behavioural model.

module tb_studio2_keypad_ctrl;
  localparam int NP = 2, K = 10, HOLD = 8, SEL = 2, NK = NP * K;

  logic          clk = 0;
  logic          reset;
  logic [10:0]   ps2_key;
  logic          io_out;
  logic [2:0]    io_n;
  logic [7:0]    io_dout;
  logic [NP-1:0] ef_n;
  logic [3:0]    key_sel;
  logic [NK-1:0] key_down;
  logic [7:0]    key_code;

  int checks = 0, errors = 0;

  studio2_keypad_ctrl #(.NUM_PADS(NP), .KEYS_PER_PAD(K), .HOLD_CYCLES(HOLD), .SEL_PORT(SEL)) dut (
    .clk(clk), .reset(reset), .ps2_key(ps2_key), .io_out(io_out), .io_n(io_n),
    .io_dout(io_dout), .ef_n(ef_n), .key_sel(key_sel), .key_down(key_down), .key_code(key_code)
  );

  always #5 clk = ~clk;

  // Scancode tables: index = pad*10 + digit.
  logic [7:0] codes [NK] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                             8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

  // Model: raw press per key, and per pad a deadline edge at which stretched keys drop.
  bit            m_down [NK];
  bit            m_st   [NK];
  bit            m_act  [NP];
  int            m_exp  [NP];
  int            n = 0;
  bit            m_tog;
  logic [NK-1:0] m_kd;
  logic [NP-1:0] m_ef;
  logic [3:0]    m_sel;
  logic [7:0]    m_code;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, n, act, exp);
    end
  endtask

  task automatic model_edge();
    logic [3:0] nsel;
    int idx;
    n++;
    if (reset) begin
      for (int i = 0; i < NK; i++) begin m_down[i] = 0; m_st[i] = 0; end
      for (int p = 0; p < NP; p++) m_act[p] = 0;
      m_tog = ps2_key[10]; m_kd = '0; m_ef = '1; m_sel = 0; m_code = 8'hFF;
      return;
    end
    nsel = (io_out && io_n == 3'(SEL)) ? io_dout[3:0] : m_sel;
    for (int p = 0; p < NP; p++)
      m_ef[p] = !((nsel < 4'(K)) && m_kd[p*K + int'(nsel)]);
    m_code = 8'hFF;
`ifdef STUDIO2_KEYPAD_CODE_EN
    for (int i = NK - 1; i >= 0; i--)
      if (m_kd[i]) m_code = {4'(i / K), 4'(i % K)};
`endif
    for (int p = 0; p < NP; p++)
      if (m_act[p] && n == m_exp[p]) begin
        m_act[p] = 0;
        for (int k = 0; k < K; k++) m_st[p*K + k] = 0;
      end
    if (ps2_key[10] != m_tog && !ps2_key[8]) begin
      idx = -1;
      for (int i = 0; i < NK; i++) if (codes[i] == ps2_key[7:0]) idx = i;
      if (idx >= 0) begin
        if (ps2_key[9]) begin
          m_down[idx] = 1; m_st[idx] = 1;
          m_act[idx / K] = 1; m_exp[idx / K] = n + HOLD;
        end else m_down[idx] = 0;
      end
    end
    m_tog = ps2_key[10];
    for (int i = 0; i < NK; i++) m_kd[i] = m_down[i] | m_st[i];
    m_sel = nsel;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("key_down", 32'(key_down), 32'(m_kd));
    chk("ef_n",     32'(ef_n),     32'(m_ef));
    chk("key_sel",  32'(key_sel),  32'(m_sel));
    chk("key_code", 32'(key_code), 32'(m_code));
  endtask

  task automatic send(input bit make, input logic [7:0] sc, input bit ext = 0);
    ps2_key = {~ps2_key[10], make, ext, sc};
    tick();
  endtask

  task automatic sel_write(input logic [2:0] port, input logic [7:0] val);
    io_out = 1; io_n = port; io_dout = val;
    tick();
    io_out = 0;
  endtask

  initial begin
    reset = 1; ps2_key = '0; io_out = 0; io_n = 0; io_dout = 0;
    tick(); tick();
    reset = 0;
    tick();
    chk("pin_reset_ef", 32'(ef_n), 32'h3);
    chk("pin_reset_kd", 32'(key_down), 32'h0);
    chk("pin_reset_code", 32'(key_code), 32'hFF);

    // Make with select 0: bit 2 up one edge later, flags unaffected.
    send(1, 8'h1E);
    chk("pin_t1_kd", 32'(key_down), 32'h4);
    tick();
    chk("pin_t1_ef", 32'(ef_n), 32'h3);
    repeat (10) tick();
    send(0, 8'h1E);
    tick();

    // Select 2, make, early break: stretch holds flag until the deadline edge.
    sel_write(3'd2, 8'h02);
    send(1, 8'h1E);
    tick();
    chk("pin_t2_ef", 32'(ef_n), 32'h2);
    tick();
    send(0, 8'h1E);
    chk("pin_t2_kd_held", 32'(key_down), 32'h4);
    repeat (4) tick();
    chk("pin_t2_ef_held", 32'(ef_n), 32'h2);
    tick();
    chk("pin_t2_kd_exp", 32'(key_down), 32'h0);
    tick();
    chk("pin_t2_ef_exp", 32'(ef_n), 32'h3);

    // Numpad 3 on pad 1 held long, then released.
    sel_write(3'd2, 8'h03);
    send(1, 8'h7A);
    repeat (50) tick();
    chk("pin_t3_ef", 32'(ef_n), 32'h1);
    send(0, 8'h7A);
    tick();
    chk("pin_t3_ef_rel", 32'(ef_n), 32'h3);

    // All pad0 keys held, out-of-range select, foreign port ignored.
    for (int i = 0; i < K; i++) send(1, codes[i]);
    sel_write(3'd2, 8'h0C);
    chk("pin_t4_ef", 32'(ef_n), 32'h3);
    sel_write(3'd3, 8'h05);
    chk("pin_t4_sel", 32'(key_sel), 32'hC);

    // Reset while held, with the toggle moving during reset.
    reset = 1; ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1E};
    tick();
    reset = 0;
    tick();
    chk("pin_t5_kd", 32'(key_down), 32'h0);
    chk("pin_t5_sel", 32'(key_sel), 32'h0);
    chk("pin_t5_ef", 32'(ef_n), 32'h3);

    // Priority of key_code (fixed 8'hFF when the encoder is not built).
    send(1, 8'h2E);
    tick();
`ifdef STUDIO2_KEYPAD_CODE_EN
    chk("pin_t6_code_a", 32'(key_code), 32'h05);
`else
    chk("pin_t6_code_a", 32'(key_code), 32'hFF);
`endif
    send(1, 8'h69);
    tick();
`ifdef STUDIO2_KEYPAD_CODE_EN
    chk("pin_t6_code_b", 32'(key_code), 32'h05);
`endif
    repeat (10) tick();
    send(0, 8'h2E);
    send(0, 8'h69);
    tick();
    chk("pin_t6_code_c", 32'(key_code), 32'hFF);
    chk("pin_ext_none", 32'(key_down), 32'h0);

    // Extended make is ignored.
    send(1, 8'h1E, 1);
    chk("pin_ext_ign", 32'(key_down), 32'h0);

    // Random traffic.
    for (int c = 0; c < 5000; c++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 2) begin
        reset = 1;
        if ($urandom_range(0, 1) == 1) ps2_key[10] = ~ps2_key[10];
        tick();
        reset = 0;
      end else if (r < 70) begin
        logic [7:0] sc;
        sc = ($urandom_range(0, 9) < 8) ? codes[$urandom_range(0, NK-1)] : 8'($urandom);
        send($urandom_range(0, 2) != 0 ? 1'b0 : 1'b1, sc, $urandom_range(0, 9) == 0);
      end else if (r < 95) begin
        io_out = 1;
        io_n = ($urandom_range(0, 2) != 0) ? 3'(SEL) : 3'($urandom);
        io_dout = 8'($urandom);
        if ($urandom_range(0, 3) == 0) ps2_key = {~ps2_key[10], 1'b1, 1'b0, codes[$urandom_range(0, NK-1)]};
        tick();
        io_out = 0;
      end else tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
